// File: rtl/lif_pkg.sv
// ---------------------------------------------------------------------------
// lif_pkg
// Shared definitions for the spike-rate readout path.
//   - default channel count, window length and count width
//   - readout state enum
//   - saturating add helper, used by every per-channel counter
// ---------------------------------------------------------------------------
package lif_pkg;

    localparam int unsigned N_CH_DEF   = 3;
    localparam int unsigned WINDOW_DEF = 256;
    localparam int unsigned CNT_W_DEF  = 8;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } rd_state_e;

    // Returns a + b clamped to max_v. Callers pass values already narrower
    // than 32 bits, so the 32-bit sum cannot itself overflow.
    function automatic int unsigned sat_add(input int unsigned a,
                                            input int unsigned b,
                                            input int unsigned max_v);
        int unsigned sum;
        sum = a + b;
        return (sum > max_v) ? max_v : sum;
    endfunction

endpackage

// File: rtl/spike_rate_decoder_counter.sv
// ---------------------------------------------------------------------------
// spike_counter
// One channel of the rate decoder: a saturating live spike counter plus a
// shadow register that holds the count of the last accepted window.
// Ports:
//   clk, rst_n   - clock, asynchronous active-low reset
//   spike_i      - spike line for this channel (one cycle high = one spike)
//   win_end_i    - capture live count (+ this cycle's spike) into the shadow
//   clear_i      - window boundary: live count restarts from 0
//   shadow_o     - captured count of the last accepted window
// ---------------------------------------------------------------------------
module spike_counter
    import lif_pkg::*;
#(
    parameter int unsigned CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             spike_i,
    input  logic             win_end_i,
    input  logic             clear_i,
    output logic [CNT_W-1:0] shadow_o
);

    localparam int unsigned CNT_MAX = (32'd1 << CNT_W) - 32'd1;

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] shadow_q, shadow_d;
    logic [CNT_W-1:0] cnt_inc;

    // The spike arriving on the boundary cycle is folded into the captured
    // value, so it belongs to the window that is ending.
    always_comb begin
        // NOTE: every signal assigned here gets a value on every path; a
        // missing default would infer a latch.
        cnt_inc  = CNT_W'(sat_add(32'(cnt_q), 32'(spike_i), CNT_MAX));
        cnt_d    = clear_i   ? '0      : cnt_inc;
        shadow_d = win_end_i ? cnt_inc : shadow_q;
    end

    // NOTE: state uses non-blocking assignments so all registers update
    // together on the edge. The shadow register is reset too: it is a single
    // word per channel, not a memory, and it drives rate_out after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q    <= '0;
            shadow_q <= '0;
        end else begin
            cnt_q    <= cnt_d;
            shadow_q <= shadow_d;
        end
    end

    assign shadow_o = shadow_q;

endmodule

// File: rtl/spike_rate_decoder.sv
// ---------------------------------------------------------------------------
// spike_rate_decoder
// Counts spikes per channel over a fixed window, snapshots all counts at the
// window end and streams them out one channel per transfer.
// Ports:
//   clk, rst_n   - clock, asynchronous active-low reset
//   spike_in     - one spike line per channel
//   rate_out     - count of the presented channel
//   rate_ch      - index of the presented channel
//   rate_valid   - rate_out / rate_ch valid
//   rate_ready   - consumer accepts the presented word
//   overrun      - sticky: a window ended while a readout was in progress
// ---------------------------------------------------------------------------
module spike_rate_decoder
    import lif_pkg::*;
#(
    parameter  int unsigned N_CH   = N_CH_DEF,
    parameter  int unsigned WINDOW = WINDOW_DEF,
    parameter  int unsigned CNT_W  = CNT_W_DEF,
    localparam int unsigned CH_W   = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_CH-1:0]  spike_in,
    output logic [CNT_W-1:0] rate_out,
    output logic [CH_W-1:0]  rate_ch,
    output logic             rate_valid,
    input  logic             rate_ready,
    output logic             overrun
);

    localparam int unsigned WIN_W = $clog2(WINDOW);

    logic [WIN_W-1:0] win_cnt_q, win_cnt_d;
    logic             win_end;
    rd_state_e        state_q, state_d;
    logic [CH_W-1:0]  idx_q, idx_d;
    logic             overrun_q, overrun_d;
    logic             take_snapshot;
    logic [CNT_W-1:0] shadow [N_CH];

    // ---------------- window counter ----------------
    assign win_end   = (win_cnt_q == WIN_W'(WINDOW - 1));
    assign win_cnt_d = win_end ? '0 : win_cnt_q + WIN_W'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) win_cnt_q <= '0;
        else        win_cnt_q <= win_cnt_d;
    end

    // A window ending mid-readout is dropped; the live counters still restart.
    assign take_snapshot = win_end && (state_q == IDLE);

    for (genvar c = 0; c < N_CH; c++) begin : g_ch
        spike_counter #(.CNT_W(CNT_W)) u_cnt (
            .clk       (clk),
            .rst_n     (rst_n),
            .spike_i   (spike_in[c]),
            .win_end_i (take_snapshot),
            .clear_i   (win_end),
            .shadow_o  (shadow[c])
        );
    end

    // ---------------- readout FSM: state register ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

    // ---------------- readout FSM: next state ----------------
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        unique case (state_q)
            IDLE: begin
                if (win_end) begin
                    state_d = SEND;
                    idx_d   = '0;
                end
            end
            SEND: begin
                if (rate_ready) begin
                    if (idx_q == CH_W'(N_CH - 1)) state_d = IDLE;
                    else                          idx_d   = idx_q + CH_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // ---------------- readout FSM: outputs ----------------
    // Outputs depend on registered state only, so rate_ready never reaches
    // an output combinationally.
    always_comb begin
        rate_valid = 1'b0;
        rate_ch    = '0;
        rate_out   = '0;
        if (state_q == SEND) begin
            rate_valid = 1'b1;
            rate_ch    = idx_q;
            rate_out   = shadow[idx_q];
        end
    end

    // ---------------- sticky overrun ----------------
    assign overrun_d = overrun_q | (win_end && (state_q == SEND));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) overrun_q <= 1'b0;
        else        overrun_q <= overrun_d;
    end

    assign overrun = overrun_q;

endmodule

// File: tb/tb_spike_rate_decoder.sv
// ---------------------------------------------------------------------------
// tb_spike_rate_decoder
// Directed bench: main instance (N_CH=3, WINDOW=16, CNT_W=8) plus a
// CNT_W=4 instance sharing clock/reset to show saturation.
// Edge numbering in comments: E1 is the first rising edge after reset
// release; window w ends on edge E(16*w).
// ---------------------------------------------------------------------------
module tb_spike_rate_decoder;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [2:0] spike_in;
    logic [2:0] spike_sat;
    logic       rate_ready;

    logic [7:0] rate_out;
    logic [1:0] rate_ch;
    logic       rate_valid;
    logic       overrun;

    logic [3:0] sat_out;
    logic [1:0] sat_ch;
    logic       sat_valid;
    logic       sat_overrun;

    int n_tests = 0;
    int n_fail  = 0;

    // Backpressure table: ready per cycle, expected valid/channel/rate after it
    bit w5_rdy [10] = '{0, 0, 0, 0, 0, 1, 0, 1, 0, 1};
    int w5_ev  [10] = '{1, 1, 1, 1, 1, 1, 1, 1, 1, 0};
    int w5_ch  [10] = '{0, 0, 0, 0, 0, 1, 1, 2, 2, 0};
    int w5_out [10] = '{3, 3, 3, 3, 3, 7, 7, 2, 2, 0};

    always #5 clk = ~clk;

    spike_rate_decoder #(.N_CH(3), .WINDOW(16), .CNT_W(8)) u_dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .spike_in   (spike_in),
        .rate_out   (rate_out),
        .rate_ch    (rate_ch),
        .rate_valid (rate_valid),
        .rate_ready (rate_ready),
        .overrun    (overrun)
    );

    spike_rate_decoder #(.N_CH(3), .WINDOW(16), .CNT_W(4)) u_sat (
        .clk        (clk),
        .rst_n      (rst_n),
        .spike_in   (spike_sat),
        .rate_out   (sat_out),
        .rate_ch    (sat_ch),
        .rate_valid (sat_valid),
        .rate_ready (rate_ready),
        .overrun    (sat_overrun)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_word(input string tag, input int ch, input int val);
        check({tag, "_valid"}, 32'(rate_valid), 32'd1);
        check({tag, "_ch"},    32'(rate_ch),    32'(ch));
        check({tag, "_rate"},  32'(rate_out),   32'(val));
    endtask

    // Inputs change 1 time unit after the rising edge; outputs are sampled there.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n      = 1'b0;
        spike_in   = '0;
        spike_sat  = '0;
        rate_ready = 1'b1;
        tick();
        tick();
        check("rst_valid",   32'(rate_valid), 32'd0);
        check("rst_rate",    32'(rate_out),   32'd0);
        check("rst_ch",      32'(rate_ch),    32'd0);
        check("rst_overrun", 32'(overrun),    32'd0);
        rst_n = 1'b1;

        // ---- W1: no spikes; first window end on E16 ----
        for (int i = 0; i < 15; i++) tick();
        check("w1_pre_valid", 32'(rate_valid), 32'd0);
        tick();
        check_word("w1_ch0", 0, 0);

        // ---- W2: ch0 every cycle, ch1 five cycles, ch2 on window end only ----
        for (int i = 0; i < 16; i++) begin
            spike_in[0] = 1'b1;
            spike_in[1] = (i % 2 == 1) && (i < 10);
            spike_in[2] = (i == 15);
            spike_sat   = 3'b001;
            tick();
            if (i == 0) check_word("w1_ch1", 1, 0);
            if (i == 1) check_word("w1_ch2", 2, 0);
            if (i == 2) check("w1_done_valid", 32'(rate_valid), 32'd0);
        end
        check_word("w2_ch0", 0, 16);
        check("sat_valid", 32'(sat_valid), 32'd1);
        check("sat_rate",  32'(sat_out),   32'd15);
        spike_in  = '0;
        spike_sat = '0;

        // ---- W3: no spikes ----
        for (int i = 0; i < 16; i++) begin
            tick();
            if (i == 0) check_word("w2_ch1", 1, 5);
            if (i == 1) check_word("w2_ch2", 2, 1);
            if (i == 2) check("w2_done_valid", 32'(rate_valid), 32'd0);
        end
        check_word("w3_ch0", 0, 0);

        // ---- W4: ch0 x3, ch1 x7, ch2 x2 ----
        for (int i = 0; i < 16; i++) begin
            spike_in[0] = (i < 3);
            spike_in[1] = (i >= 4) && (i <= 10);
            spike_in[2] = (i == 12) || (i == 13);
            if (i == 15) rate_ready = 1'b0;
            tick();
            if (i == 0) check_word("w3_ch1", 1, 0);
            if (i == 1) check_word("w3_ch2", 2, 0);
            if (i == 2) check("w3_done_valid", 32'(rate_valid), 32'd0);
        end
        check_word("w4_ch0", 0, 3);

        // ---- W5: ch0 x4; backpressure on the W4 readout ----
        for (int i = 0; i < 16; i++) begin
            spike_in    = {2'b00, 1'(i < 4)};
            rate_ready  = (i < 10) ? w5_rdy[i] : 1'b1;
            if (i == 15) rate_ready = 1'b0;
            tick();
            if (i < 10) begin
                check($sformatf("bp%0d_valid", i), 32'(rate_valid), 32'(w5_ev[i]));
                if (w5_ev[i] == 1) begin
                    check($sformatf("bp%0d_ch", i),   32'(rate_ch),  32'(w5_ch[i]));
                    check($sformatf("bp%0d_rate", i), 32'(rate_out), 32'(w5_out[i]));
                end
            end
            if (i == 10) check("bp_after_valid", 32'(rate_valid), 32'd0);
        end
        check_word("w5_ch0", 0, 4);
        check("w5_overrun", 32'(overrun), 32'd0);

        // ---- W6: ch1 x2; ready held low across the W6 window end ----
        for (int i = 0; i < 16; i++) begin
            spike_in = {1'b0, 1'(i < 2), 1'b0};
            tick();
            check($sformatf("hold%0d_rate", i), 32'(rate_out), 32'd4);
            if (i == 14) check("pre_overrun", 32'(overrun), 32'd0);
        end
        check_word("ovr_ch0", 0, 4);
        check("ovr_set", 32'(overrun), 32'd1);

        // ---- W7: ch2 x6; old snapshot drains, W6 data must not appear ----
        rate_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            spike_in = {1'((i >= 3) && (i <= 8)), 2'b00};
            tick();
            if (i == 0) check_word("ovr_ch1", 1, 0);
            if (i == 1) check_word("ovr_ch2", 2, 0);
            if (i == 2) check("ovr_done_valid", 32'(rate_valid), 32'd0);
        end
        check_word("w7_ch0", 0, 0);

        // ---- W8: ch0 x5 ----
        for (int i = 0; i < 16; i++) begin
            spike_in = {2'b00, 1'(i < 5)};
            if (i == 15) rate_ready = 1'b0;
            tick();
            if (i == 0) check_word("w7_ch1", 1, 0);
            if (i == 1) check_word("w7_ch2", 2, 6);
            if (i == 2) check("w7_overrun_sticky", 32'(overrun), 32'd1);
        end
        check_word("w8_ch0", 0, 5);

        // ---- reset in the middle of a readout and a window ----
        spike_in = 3'b010;
        for (int i = 0; i < 3; i++) tick();
        rst_n = 1'b0;
        #1;
        check("mid_rst_valid",   32'(rate_valid), 32'd0);
        check("mid_rst_overrun", 32'(overrun),    32'd0);
        check("mid_rst_rate",    32'(rate_out),   32'd0);
        tick();
        rst_n      = 1'b1;
        rate_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            spike_in = {2'b00, 1'(i < 3)};
            tick();
            if (i == 14) check("rr_pre_valid", 32'(rate_valid), 32'd0);
        end
        spike_in = '0;
        check_word("rr_ch0", 0, 3);
        tick();
        check_word("rr_ch1", 1, 0);
        tick();
        check_word("rr_ch2", 2, 0);
        tick();
        check("rr_done_valid", 32'(rate_valid), 32'd0);
        check("rr_overrun",    32'(overrun),    32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
